// File: rtl/kp_pkg.sv
// Shared keypoint types for the feeder and the matcher-side blocks.
package kp_pkg;

   localparam int unsigned KP_DESC_W  = 256;
   localparam int unsigned KP_COOR_W  = 10;
   localparam int unsigned KP_SCORE_W = 8;

   typedef struct packed {
      logic [KP_COOR_W-1:0]  x;
      logic [KP_COOR_W-1:0]  y;
      logic [KP_SCORE_W-1:0] score;
      logic [KP_DESC_W-1:0]  desc;
   } kp_t;

   localparam int unsigned KP_W = $bits(kp_t);

   // FIFO entry: end-of-frame tag above the keypoint payload
   typedef struct packed {
      logic eof;
      kp_t  kp;
   } kp_entry_t;

   localparam int unsigned KP_ENTRY_W = $bits(kp_entry_t);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_END  = 2'd2
   } feed_state_t;

endpackage

// File: rtl/kp_fifo.sv
// Synchronous FIFO with combinational head read; pointers wrap modulo DEPTH.
module kp_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned W      = 285,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic [W-1:0]    i_data,
   input  logic            i_pop,
   output logic [W-1:0]    o_data,
   output logic            o_full,
   output logic            o_empty,
   output logic [ADDR_W:0] o_count
);

   logic [W-1:0]      mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign o_full  = (o_count == (ADDR_W+1)'(DEPTH));
   assign o_empty = (o_count == '0);
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;
   assign o_data  = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   o_count <= o_count + 1'b1;
            2'b01:   o_count <= o_count - 1'b1;
            default: o_count <= o_count;
         endcase
      end
   end

endmodule

// File: rtl/keypoint_feeder.sv
// Keypoint hand-off into the frame matcher: FIFO, one-entry output stage,
// flag/next keypoint handshake and end/ack frame close.
module keypoint_feeder
   import kp_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic                  i_eof,
   input  logic [KP_COOR_W-1:0]  i_coor_x,
   input  logic [KP_COOR_W-1:0]  i_coor_y,
   input  logic [KP_SCORE_W-1:0] i_score,
   input  logic [KP_DESC_W-1:0]  i_desc,
   output logic                  o_ready,
   output logic                  o_flag,
   output logic [KP_COOR_W-1:0]  o_coor_x,
   output logic [KP_COOR_W-1:0]  o_coor_y,
   output logic [KP_SCORE_W-1:0] o_score,
   output logic [KP_DESC_W-1:0]  o_desc,
   input  logic                  i_next,
   output logic                  o_end,
   input  logic                  i_end_ack,
   output logic [CNT_W-1:0]      o_frame_kp
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   feed_state_t     state;
   feed_state_t     state_nx;
   kp_entry_t       wr_entry;
   kp_entry_t       head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [ADDR_W:0] fifo_count;
   logic            push;
   logic            pop;
   logic [CNT_W-1:0] kp_cnt;

   assign o_ready  = (fifo_count != (ADDR_W+1)'(DEPTH));
   assign push     = i_valid && !fifo_full;
   assign wr_entry = '{eof: i_eof,
                       kp: '{x: i_coor_x, y: i_coor_y, score: i_score, desc: i_desc}};

   kp_fifo #(
      .DEPTH (DEPTH),
      .W     (KP_ENTRY_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (wr_entry),
      .i_pop   (pop),
      .o_data  (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Every release of the output stage refills it on the same edge when
   // the FIFO has data, which gives back-to-back delivery.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         ST_IDLE: begin
            pop = !fifo_empty;
         end
         ST_SEND: begin
            if (i_next) begin
               pop      = !fifo_empty;
               state_nx = ST_IDLE;
            end
         end
         ST_END: begin
            if (i_end_ack) begin
               pop      = !fifo_empty;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (pop) state_nx = head.eof ? ST_END : ST_SEND;
   end

   assign o_flag = (state == ST_SEND);
   assign o_end  = (state == ST_END);

   // End markers leave the payload untouched so it holds its last value
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_coor_x <= '0;
         o_coor_y <= '0;
         o_score  <= '0;
         o_desc   <= '0;
      end else if (pop && !head.eof) begin
         o_coor_x <= head.kp.x;
         o_coor_y <= head.kp.y;
         o_score  <= head.kp.score;
         o_desc   <= head.kp.desc;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         kp_cnt     <= '0;
         o_frame_kp <= '0;
      end else if (state == ST_SEND && i_next) begin
         if (kp_cnt != '1) kp_cnt <= kp_cnt + 1'b1;
      end else if (state == ST_END && i_end_ack) begin
         o_frame_kp <= kp_cnt;
         kp_cnt     <= '0;
      end
   end

endmodule

// File: tb/tb_keypoint_feeder.sv
// Directed bench for keypoint_feeder with hand-computed expectations.
module tb_keypoint_feeder;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_valid;
   logic         i_eof;
   logic [9:0]   i_coor_x;
   logic [9:0]   i_coor_y;
   logic [7:0]   i_score;
   logic [255:0] i_desc;
   logic         o_ready;
   logic         o_flag;
   logic [9:0]   o_coor_x;
   logic [9:0]   o_coor_y;
   logic [7:0]   o_score;
   logic [255:0] o_desc;
   logic         i_next;
   logic         o_end;
   logic         i_end_ack;
   logic [9:0]   o_frame_kp;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   keypoint_feeder #(
      .DEPTH (16),
      .CNT_W (10)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .i_eof      (i_eof),
      .i_coor_x   (i_coor_x),
      .i_coor_y   (i_coor_y),
      .i_score    (i_score),
      .i_desc     (i_desc),
      .o_ready    (o_ready),
      .o_flag     (o_flag),
      .o_coor_x   (o_coor_x),
      .o_coor_y   (o_coor_y),
      .o_score    (o_score),
      .o_desc     (o_desc),
      .i_next     (i_next),
      .o_end      (o_end),
      .i_end_ack  (i_end_ack),
      .o_frame_kp (o_frame_kp)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [255:0] mk_desc(input int unsigned n);
      logic [31:0] w;
      w = 32'hD000_0000 + n;
      return {8{w}};
   endfunction

   function automatic logic [283:0] mk_kp(input int unsigned x, input int unsigned y,
                                          input int unsigned s);
      logic [9:0] xx;
      logic [9:0] yy;
      logic [7:0] ss;
      xx = x[9:0];
      yy = y[9:0];
      ss = s[7:0];
      return {xx, yy, ss, mk_desc(x)};
   endfunction

   function automatic logic [283:0] out_payload();
      return {o_coor_x, o_coor_y, o_score, o_desc};
   endfunction

   task automatic push(input logic eof, input logic [283:0] kp);
      int unsigned n;
      n = 0;
      i_valid = 1'b1;
      i_eof   = eof;
      {i_coor_x, i_coor_y, i_score, i_desc} = kp;
      while (!o_ready && n < 200) begin
         tick();
         n++;
      end
      chk("push_ready", o_ready, 1);
      tick();
      i_valid = 1'b0;
      i_eof   = 1'b0;
   endtask

   task automatic expect_kp(input logic [283:0] kp);
      int unsigned n;
      n = 0;
      while (!o_flag && n < 100) begin
         tick();
         n++;
      end
      chk("kp_flag", o_flag, 1);
      chk("kp_excl", o_end, 0);
      chk("kp_payload", out_payload(), kp);
      i_next = 1'b1;
      tick();
      i_next = 1'b0;
   endtask

   task automatic expect_end(input int unsigned exp_cnt);
      int unsigned n;
      n = 0;
      while (!o_end && n < 100) begin
         tick();
         n++;
      end
      chk("end_high", o_end, 1);
      chk("end_excl", o_flag, 0);
      i_end_ack = 1'b1;
      tick();
      i_end_ack = 1'b0;
      chk("end_drop", o_end, 0);
      chk("frame_kp", o_frame_kp, exp_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [283:0] held;
      int unsigned  bad;
      int unsigned  q[$];
      int unsigned  idx;
      logic         rdy;

      i_rst_n = 1'b0; i_valid = 1'b0; i_eof = 1'b0; i_next = 1'b0; i_end_ack = 1'b0;
      i_coor_x = '0; i_coor_y = '0; i_score = '0; i_desc = '0;
      tick(); tick();
      chk("rst_flag", o_flag, 0);
      chk("rst_end", o_end, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_frame_kp", o_frame_kp, 0);
      chk("rst_payload", out_payload(), 0);
      i_rst_n = 1'b1;
      tick();

      // single keypoint, latency 2, hold until next, then frame end
      push(1'b0, mk_kp(12, 34, 200));
      chk("lat_k", o_flag, 0);
      tick();
      chk("lat_k1", o_flag, 1);
      chk("single_payload", out_payload(), mk_kp(12, 34, 200));
      tick(); tick(); tick();
      chk("single_hold", o_flag, 1);
      expect_kp(mk_kp(12, 34, 200));
      chk("single_idle", o_flag, 0);
      push(1'b1, '0);
      expect_end(1);

      // consumer stall for 600 cycles; stray acks in SEND are ignored
      push(1'b0, mk_kp(1, 2, 3));
      push(1'b0, mk_kp(4, 5, 6));
      push(1'b0, mk_kp(7, 8, 9));
      push(1'b1, '0);
      held = mk_kp(1, 2, 3);
      bad  = 0;
      for (int i = 0; i < 600; i++) begin
         i_end_ack = (i % 7 == 0);
         if (!o_flag || o_end || out_payload() !== held) bad++;
         tick();
      end
      i_end_ack = 1'b0;
      chk("stall_stable", bad, 0);
      chk("stall_frame_kp", o_frame_kp, 1);
      expect_kp(mk_kp(1, 2, 3));
      expect_kp(mk_kp(4, 5, 6));
      expect_kp(mk_kp(7, 8, 9));
      expect_end(3);

      // backpressure: 16 in FIFO plus 1 in the output stage
      for (int unsigned i = 0; i < 20; i++) begin
         i_valid = 1'b1;
         i_eof   = 1'b0;
         {i_coor_x, i_coor_y, i_score, i_desc} = mk_kp(100 + i, 200 + i, i);
         rdy = o_ready;
         tick();
         if (rdy) q.push_back(i);
      end
      i_valid = 1'b0;
      chk("bp_accepted", q.size(), 17);
      chk("bp_ready_low", o_ready, 0);
      while (q.size() > 0) begin
         idx = q.pop_front();
         expect_kp(mk_kp(100 + idx, 200 + idx, idx));
      end
      chk("bp_ready_back", o_ready, 1);
      push(1'b1, '0);
      expect_end(17);

      // back-to-back delivery with i_next held high
      for (int unsigned i = 0; i < 5; i++) push(1'b0, mk_kp(300 + i, 400 + i, 50 + i));
      push(1'b1, '0);
      i_next = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         chk("b2b_flag", o_flag, 1);
         chk("b2b_excl", o_end, 0);
         chk("b2b_payload", out_payload(), mk_kp(300 + i, 400 + i, 50 + i));
         tick();
      end
      chk("b2b_end", o_end, 1);
      chk("b2b_end_excl", o_flag, 0);
      tick();
      chk("b2b_end_hold", o_end, 1);
      i_next = 1'b0;
      expect_end(5);

      // empty frames; i_next during END is ignored
      for (int r = 0; r < 2; r++) begin
         push(1'b1, '0);
         tick();
         chk("empty_end", o_end, 1);
         i_next = 1'b1;
         tick(); tick();
         i_next = 1'b0;
         chk("empty_end_hold", o_end, 1);
         expect_end(0);
      end

      // asynchronous reset while in END with 4 entries queued
      push(1'b1, '0);
      for (int unsigned i = 0; i < 4; i++) push(1'b0, mk_kp(500 + i, 600 + i, i));
      chk("rst_pre_end", o_end, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_end", o_end, 0);
      chk("arst_flag", o_flag, 0);
      chk("arst_ready", o_ready, 1);
      chk("arst_payload", out_payload(), 0);
      tick();
      i_rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_flag || o_end || !o_ready) bad++;
      end
      chk("arst_quiet", bad, 0);
      push(1'b0, mk_kp(21, 22, 23));
      expect_kp(mk_kp(21, 22, 23));
      push(1'b1, '0);
      expect_end(1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
